// File: rtl/pingpong_ram_ctrl.sv
// Ping-pong capture controller: ADC samples fill one external SRAM bank while the
// other bank is read out word by word to the readout sink; banks swap per frame.
module pingpong_ram_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  len_sel,
    input  logic        smp_valid,
    input  logic [11:0] smp_data,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        rd_sop,
    output logic        rd_eop,
    input  logic        rd_ready,
    output logic [18:0] ram_a0,
    output logic [18:0] ram_a1,
    output logic [15:0] ram_do0,
    output logic [15:0] ram_do1,
    input  logic [15:0] ram_di0,
    input  logic [15:0] ram_di1,
    output logic        ram_we0_n,
    output logic        ram_we1_n,
    output logic        ram_oe0_n,
    output logic        ram_oe1_n,
    output logic        ram_drv0,
    output logic        ram_drv1,
    output logic [15:0] overrun_cnt,
    output logic [15:0] frame_cnt
);

    typedef enum logic {W_RUN, W_HOLD} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_DATA} r_state_t;

    // Last address of a frame for a length code (codes above 10 behave as 10).
    function automatic logic [18:0] len_last(input logic [3:0] code);
        logic [4:0] sh;
        sh = (code > 4'd10) ? 5'd18 : ({1'b0, code} + 5'd8);
        return (19'd1 << sh) - 19'd1;
    endfunction

    function automatic logic [15:0] sext12(input logic [11:0] x);
        return {{4{x[11]}}, x};
    endfunction

    w_state_t    w_state_q, w_state_d;
    r_state_t    r_state_q, r_state_d;
    logic        wsel_q, wsel_d;
    logic [18:0] wr_addr_q, wr_addr_d;
    logic [18:0] nw_last_q, nw_last_d;
    logic [18:0] rd_addr_q, rd_addr_d;
    logic [18:0] nr_last_q, nr_last_d;
    logic        rd_valid_q, rd_valid_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_sop_q, rd_sop_d;
    logic        rd_eop_q, rd_eop_d;
    logic [15:0] overrun_q, overrun_d;
    logic [15:0] frame_q, frame_d;

    logic [18:0] ram_a_q [2];
    logic [18:0] ram_a_d [2];
    logic [15:0] ram_do_q [2];
    logic [15:0] ram_do_d [2];
    logic [1:0]  ram_we_n_q, ram_we_n_d;
    logic [1:0]  ram_oe_n_q, ram_oe_n_d;
    logic [1:0]  ram_drv_q, ram_drv_d;

    logic        wr_acc;
    logic        rd_drive;
    logic [18:0] frame_last;
    logic        rd_done;
    logic        swap;

    assign wr_acc     = (w_state_q == W_RUN) && smp_valid;
    assign rd_drive   = (r_state_q == R_ADDR) || (r_state_q == R_WAIT);
    assign frame_last = (wr_addr_q == 19'd0) ? len_last(len_sel) : nw_last_q;
    assign rd_done    = (r_state_q == R_DATA) && rd_ready && (rd_addr_q == nr_last_q);

    always_comb begin
        w_state_d = w_state_q;
        r_state_d = r_state_q;
        wsel_d    = wsel_q;
        wr_addr_d = wr_addr_q;
        nw_last_d = nw_last_q;
        rd_addr_d = rd_addr_q;
        nr_last_d = nr_last_q;
        rd_data_d = rd_data_q;
        rd_sop_d  = rd_sop_q;
        rd_eop_d  = rd_eop_q;
        overrun_d = overrun_q;
        frame_d   = frame_q;
        swap      = 1'b0;

        case (r_state_q)
            R_ADDR: r_state_d = R_WAIT;
            R_WAIT: begin
                r_state_d = R_DATA;
                rd_data_d = wsel_q ? ram_di0 : ram_di1;
                rd_sop_d  = (rd_addr_q == 19'd0);
                rd_eop_d  = (rd_addr_q == nr_last_q);
            end
            R_DATA: begin
                if (rd_ready) begin
                    if (rd_done) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + 19'd1;
                        r_state_d = R_ADDR;
                    end
                end
            end
            default: ;
        endcase

        // A reader finishing in this very cycle counts as idle for the swap.
        case (w_state_q)
            W_RUN: begin
                if (wr_acc) begin
                    if (wr_addr_q == 19'd0) nw_last_d = len_last(len_sel);
                    if (wr_addr_q == frame_last) begin
                        frame_d = frame_q + 16'd1;
                        if ((r_state_q == R_IDLE) || rd_done) swap = 1'b1;
                        else w_state_d = W_HOLD;
                    end else begin
                        wr_addr_d = wr_addr_q + 19'd1;
                    end
                end
            end
            default: begin
                if (smp_valid && (overrun_q != 16'hFFFF)) overrun_d = overrun_q + 16'd1;
                if (r_state_q == R_IDLE) swap = 1'b1;
            end
        endcase

        if (swap) begin
            wsel_d    = ~wsel_q;
            wr_addr_d = 19'd0;
            w_state_d = W_RUN;
            r_state_d = R_ADDR;
            rd_addr_d = 19'd0;
            nr_last_d = nw_last_q;
        end

        rd_valid_d = (r_state_d == R_DATA);
    end

    // Reader pins follow the registered reader state, so a bank handed over by
    // the writer never sees its last write pulse and a read enable together.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            ram_a_d[b]    = ram_a_q[b];
            ram_do_d[b]   = ram_do_q[b];
            ram_we_n_d[b] = 1'b1;
            ram_oe_n_d[b] = 1'b1;
            ram_drv_d[b]  = 1'b0;
            if (wr_acc && (wsel_q == b[0])) begin
                ram_a_d[b]    = wr_addr_q;
                ram_do_d[b]   = sext12(smp_data);
                ram_we_n_d[b] = 1'b0;
                ram_drv_d[b]  = 1'b1;
            end else if (rd_drive && (wsel_q != b[0])) begin
                ram_a_d[b]    = rd_addr_q;
                ram_oe_n_d[b] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q   <= W_RUN;
            r_state_q   <= R_IDLE;
            wsel_q      <= 1'b0;
            wr_addr_q   <= '0;
            nw_last_q   <= '0;
            rd_addr_q   <= '0;
            nr_last_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_sop_q    <= 1'b0;
            rd_eop_q    <= 1'b0;
            overrun_q   <= '0;
            frame_q     <= '0;
            ram_a_q[0]  <= '0;
            ram_a_q[1]  <= '0;
            ram_do_q[0] <= '0;
            ram_do_q[1] <= '0;
            ram_we_n_q  <= 2'b11;
            ram_oe_n_q  <= 2'b11;
            ram_drv_q   <= 2'b00;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            wsel_q      <= wsel_d;
            wr_addr_q   <= wr_addr_d;
            nw_last_q   <= nw_last_d;
            rd_addr_q   <= rd_addr_d;
            nr_last_q   <= nr_last_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_sop_q    <= rd_sop_d;
            rd_eop_q    <= rd_eop_d;
            overrun_q   <= overrun_d;
            frame_q     <= frame_d;
            ram_a_q[0]  <= ram_a_d[0];
            ram_a_q[1]  <= ram_a_d[1];
            ram_do_q[0] <= ram_do_d[0];
            ram_do_q[1] <= ram_do_d[1];
            ram_we_n_q  <= ram_we_n_d;
            ram_oe_n_q  <= ram_oe_n_d;
            ram_drv_q   <= ram_drv_d;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_sop      = rd_sop_q;
    assign rd_eop      = rd_eop_q;
    assign ram_a0      = ram_a_q[0];
    assign ram_a1      = ram_a_q[1];
    assign ram_do0     = ram_do_q[0];
    assign ram_do1     = ram_do_q[1];
    assign ram_we0_n   = ram_we_n_q[0];
    assign ram_we1_n   = ram_we_n_q[1];
    assign ram_oe0_n   = ram_oe_n_q[0];
    assign ram_oe1_n   = ram_oe_n_q[1];
    assign ram_drv0    = ram_drv_q[0];
    assign ram_drv1    = ram_drv_q[1];
    assign overrun_cnt = overrun_q;
    assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_pingpong_ram_ctrl.sv
// Directed bench for pingpong_ram_ctrl with two asynchronous SRAM bank models.
module tb_pingpong_ram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  len_sel;
    logic        smp_valid;
    logic [11:0] smp_data;
    logic        rd_valid, rd_sop, rd_eop, rd_ready;
    logic [15:0] rd_data;
    logic [18:0] ram_a0, ram_a1;
    logic [15:0] ram_do0, ram_do1, ram_di0, ram_di1;
    logic        ram_we0_n, ram_we1_n, ram_oe0_n, ram_oe1_n, ram_drv0, ram_drv1;
    logic [15:0] overrun_cnt, frame_cnt;

    always #5 clk = ~clk;

    pingpong_ram_ctrl dut (
        .clk(clk), .reset(reset), .len_sel(len_sel),
        .smp_valid(smp_valid), .smp_data(smp_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_sop(rd_sop), .rd_eop(rd_eop),
        .rd_ready(rd_ready),
        .ram_a0(ram_a0), .ram_a1(ram_a1), .ram_do0(ram_do0), .ram_do1(ram_do1),
        .ram_di0(ram_di0), .ram_di1(ram_di1),
        .ram_we0_n(ram_we0_n), .ram_we1_n(ram_we1_n),
        .ram_oe0_n(ram_oe0_n), .ram_oe1_n(ram_oe1_n),
        .ram_drv0(ram_drv0), .ram_drv1(ram_drv1),
        .overrun_cnt(overrun_cnt), .frame_cnt(frame_cnt)
    );

    logic [15:0] mem0 [0:524287];
    logic [15:0] mem1 [0:524287];
    always @(posedge clk) begin
        if (!ram_we0_n) mem0[ram_a0] <= ram_do0;
        if (!ram_we1_n) mem1[ram_a1] <= ram_do1;
    end
    assign ram_di0 = !ram_oe0_n ? mem0[ram_a0] : 16'hDEAD;
    assign ram_di1 = !ram_oe1_n ? mem1[ram_a1] : 16'hDEAD;

    typedef struct packed { logic bank; logic [18:0] a; logic [15:0] d; } wr_t;
    wr_t         wr_log[$], wr_exp[$];
    logic [17:0] rd_log[$], rd_exp[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sx(input logic [11:0] x);
        return {{4{x[11]}}, x};
    endfunction

    function automatic logic [15:0] f3(input int k);
        return (k == 0) ? 16'h0123 : sx(12'((k * 37 + 32'h700) & 32'hFFF));
    endfunction

    // Bus monitor: logs writes and accepted words, checks bank exclusivity and
    // that a stalled readout word stays put.
    logic        pv = 1'b0, pr = 1'b0;
    logic [17:0] pword = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (!ram_we0_n) wr_log.push_back({1'b0, ram_a0, ram_do0});
            if (!ram_we1_n) wr_log.push_back({1'b1, ram_a1, ram_do1});
            if (rd_valid && rd_ready) rd_log.push_back({rd_sop, rd_eop, rd_data});
            chk("bank_excl", 32'((!ram_we0_n && !ram_oe0_n) || (ram_drv0 && !ram_oe0_n) ||
                                 (!ram_we1_n && !ram_oe1_n) || (ram_drv1 && !ram_oe1_n) ||
                                 (!ram_oe0_n && !ram_oe1_n) || (!ram_we0_n && !ram_we1_n)), 32'd0);
            if (pv && !pr) chk("rd_hold", 32'({rd_valid, rd_sop, rd_eop, rd_data}), 32'({1'b1, pword}));
        end
        pv    <= rd_valid && !reset;
        pr    <= rd_ready;
        pword <= {rd_sop, rd_eop, rd_data};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rd"}, 32'({rd_valid, rd_sop, rd_eop, rd_data}), 32'd0);
        chk({tag, "_we_oe"}, 32'({ram_we0_n, ram_we1_n, ram_oe0_n, ram_oe1_n}), 32'hF);
        chk({tag, "_drv"}, 32'({ram_drv0, ram_drv1}), 32'd0);
        chk({tag, "_a0"}, 32'(ram_a0), 32'd0);
        chk({tag, "_a1"}, 32'(ram_a1), 32'd0);
        chk({tag, "_cnt"}, {overrun_cnt, frame_cnt}, 32'd0);
    endtask

    task automatic cmp_wr(input string tag);
        int bad = 0;
        chk({tag, "_wr_n"}, 32'(wr_log.size()), 32'(wr_exp.size()));
        for (int i = 0; i < wr_exp.size() && i < wr_log.size(); i++)
            if (wr_log[i] !== wr_exp[i]) bad++;
        chk({tag, "_wr_bad"}, 32'(bad), 32'd0);
        wr_log.delete();
        wr_exp.delete();
    endtask

    task automatic cmp_rd(input string tag);
        int bad = 0;
        chk({tag, "_rd_n"}, 32'(rd_log.size()), 32'(rd_exp.size()));
        for (int i = 0; i < rd_exp.size() && i < rd_log.size(); i++)
            if (rd_log[i] !== rd_exp[i]) bad++;
        chk({tag, "_rd_bad"}, 32'(bad), 32'd0);
        rd_log.delete();
        rd_exp.delete();
    endtask

    initial begin
        int k;
        logic found;
        reset = 1'b1; len_sel = 4'd0; smp_valid = 1'b0; smp_data = '0; rd_ready = 1'b0;
        step();
        step();
        check_reset_state("rst");
        reset = 1'b0;

        // V1: 256-sample ramp into bank 0; reader stalls on word 0.
        for (int i = 0; i < 256; i++) begin
            smp_valid = 1'b1;
            smp_data  = 12'(i);
            wr_exp.push_back({1'b0, 19'(i), 16'(i)});
            rd_exp.push_back({i == 0, i == 255, 16'(i)});
            step();
        end
        smp_valid = 1'b0;
        chk("v1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("v1_last_wr", 32'({ram_we0_n, ram_a0, ram_do0[11:0]}), 32'({1'b0, 19'd255, 12'd255}));
        chk("v1_rd_valid_t1", 32'(rd_valid), 32'd0);
        step();
        chk("v1_rd_pins", 32'({ram_oe0_n, ram_we0_n, ram_drv0, ram_a0}), 32'({1'b0, 1'b1, 1'b0, 19'd0}));
        step();
        chk("v1_first_word", 32'({rd_valid, rd_sop, rd_eop, rd_data}), 32'({3'b110, 16'd0}));
        step(); step(); step();
        chk("v1_stall", 32'({rd_valid, rd_data}), 32'({1'b1, 16'd0}));

        // V2/V3: second frame into bank 1 while the reader is stalled.
        for (int i = 0; i < 256; i++) begin
            smp_valid = 1'b1;
            smp_data  = (i == 0) ? 12'h800 : 12'(i);
            wr_exp.push_back({1'b1, 19'(i), (i == 0) ? 16'hF800 : 16'(i)});
            step();
            if (i == 0) chk("v2_sext", 32'({ram_we1_n, ram_a1, ram_do1}), 32'({1'b0, 19'd0, 16'hF800}) & 32'hFFFFFFFF);
        end
        smp_valid = 1'b0;
        step();
        chk("v3_frame_cnt", 32'(frame_cnt), 32'd2);
        for (int j = 0; j < 10; j++) begin
            smp_valid = 1'b1;
            smp_data  = 12'h555;
            step();
        end
        smp_valid = 1'b0;
        step();
        chk("v3_overrun", 32'(overrun_cnt), 32'd10);
        step();
        cmp_wr("v3");

        rd_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            if (rd_valid && rd_eop) found = 1'b1;
            else step();
        end
        chk("v3_drain_done", 32'(found), 32'd1);
        step();
        chk("v3_idle", 32'(rd_valid), 32'd0);
        smp_valid = 1'b1; smp_data = 12'h005;
        step();
        smp_data = 12'h123;
        wr_exp.push_back({1'b0, 19'd0, 16'h0123});
        step();
        smp_valid = 1'b0;
        chk("v3_resume_wr", 32'({ram_we0_n, ram_a0, ram_do0[11:0]}), 32'({1'b0, 19'd0, 12'h123}));
        chk("v3_rd_bank1", 32'({ram_oe1_n, ram_a1}), 32'd0);
        chk("v3_overrun2", 32'(overrun_cnt), 32'd11);
        step();
        chk("v3_f2_word0", 32'({rd_valid, rd_sop, rd_data}), 32'({2'b11, 16'hF800}));
        cmp_rd("v1");

        // V6: random readout of frames 2 and 3 while frame 3 is captured.
        for (int i = 0; i < 256; i++)
            rd_exp.push_back({i == 0, i == 255, (i == 0) ? 16'hF800 : 16'(i)});
        for (int i = 0; i < 256; i++)
            rd_exp.push_back({i == 0, i == 255, f3(i)});
        k = 1;
        for (int c = 0; c < 6000 && rd_log.size() < 512; c++) begin
            rd_ready = 1'($urandom_range(0, 1));
            if (k <= 255) begin
                smp_valid = 1'b1;
                smp_data  = f3(k)[11:0];
                wr_exp.push_back({1'b0, 19'(k), f3(k)});
                k++;
            end else begin
                smp_valid = 1'b0;
            end
            step();
        end
        smp_valid = 1'b0;
        rd_ready  = 1'b1;
        step(); step();
        cmp_rd("v6");
        cmp_wr("v6");
        chk("v6_cnts", {overrun_cnt, frame_cnt}, {16'd11, 16'd3});

        // V4: 512-sample frame with len_sel changed mid-frame, then a clamped code.
        len_sel = 4'd1;
        for (int i = 0; i < 512; i++) begin
            if (i == 10) len_sel = 4'd0;
            smp_valid = 1'b1;
            smp_data  = 12'(i);
            wr_exp.push_back({1'b1, 19'(i), 16'(i)});
            rd_exp.push_back({i == 0, i == 511, 16'(i)});
            step();
            if (i == 255) chk("v4_no_early_end", 32'(frame_cnt), 32'd3);
        end
        smp_valid = 1'b0;
        chk("v4_frame_end", 32'({frame_cnt, ram_a1[15:0]}), 32'({16'd4, 16'd511}));
        step();
        cmp_wr("v4a");
        len_sel = 4'd15;
        for (int i = 0; i < 3000; i++) begin
            smp_valid = 1'b1;
            smp_data  = 12'((i * 5) & 32'hFFF);
            wr_exp.push_back({1'b0, 19'(i), sx(12'((i * 5) & 32'hFFF))});
            step();
        end
        smp_valid = 1'b0;
        chk("v4_clamp_no_end", 32'(frame_cnt), 32'd4);
        chk("v4_clamp_addr", 32'({ram_we0_n, ram_a0}), 32'({1'b0, 19'd2999}));
        step();
        cmp_wr("v4b");
        cmp_rd("v4a");

        // V5: reset in the middle of readout.
        reset = 1'b1;
        step();
        reset = 1'b0;
        len_sel = 4'd0;
        for (int i = 0; i < 256; i++) begin
            smp_valid = 1'b1;
            smp_data  = 12'(i);
            wr_exp.push_back({1'b0, 19'(i), 16'(i)});
            if (i < 100) rd_exp.push_back({i == 0, 1'b0, 16'(i)});
            step();
        end
        smp_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            if (rd_valid && rd_data == 16'd100) found = 1'b1;
            else step();
        end
        chk("v5_word100", 32'(found), 32'd1);
        reset = 1'b1;
        step();
        check_reset_state("v5");
        reset = 1'b0;
        cmp_rd("v5");
        cmp_wr("v5a");
        smp_valid = 1'b1;
        smp_data  = 12'h7FF;
        wr_exp.push_back({1'b0, 19'd0, 16'h07FF});
        step();
        smp_valid = 1'b0;
        chk("v5_bank0", 32'({ram_we0_n, ram_we1_n, ram_a0}), 32'({2'b01, 19'd0}));
        step();
        cmp_wr("v5b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pingpong_ram_ctrl.md
PINGPONG_RAM_CTRL -- requirements
Module: pingpong_ram_ctrl

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- len_sel  in  4  frame length code: N = 2^(len_sel+8); values >10 are clamped to 10
- smp_valid  in  1  ADC sample strobe
- smp_data  in  12  signed ADC sample (offset already removed)
- rd_valid  out  1  readout word valid
- rd_data  out  16  readout word
- rd_sop  out  1  first word of frame, qualified by rd_valid
- rd_eop  out  1  last word of frame, qualified by rd_valid
- rd_ready  in  1  readout sink ready (USB FIFO side)
- ram_a0, ram_a1  out  19  bank 0/1 address
- ram_do0, ram_do1  out  16  bank 0/1 write data
- ram_di0, ram_di1  in  16  bank 0/1 read data
- ram_we0_n, ram_we1_n  out  1  write strobe, active-low
- ram_oe0_n, ram_oe1_n  out  1  output enable, active-low
- ram_drv0, ram_drv1  out  1  data-bus drive enable, active-high
- overrun_cnt  out  16  dropped-sample count, saturating
- frame_cnt  out  16  completed frames, wrapping
REQ-002 SHALL have no parameters; reset reset, synchronous, active-high; clock clk.

Function
REQ-003 SHALL hold two banks in strict ping-pong: the writer owns bank wsel and the reader owns bank !wsel; both SHALL never address the same bank.
REQ-004 SHALL latch clamped len_sel as Nw when the writer accepts sample 0 of a frame; Nw SHALL stay fixed until the frame ends.
REQ-005 Writer states W_RUN and W_HOLD.
REQ-006 In W_RUN, on smp_valid the writer SHALL write in that same cycle:
- address = wr_addr
- data = smp_data sign-extended to 16 bits
- we_n low for exactly one cycle, with drv=1 and oe_n=1
REQ-007 Writer SHALL accept one sample per cycle maximum.
REQ-008 When the writer accepts the sample at wr_addr = Nw-1, the frame is complete and frame_cnt SHALL increment.
REQ-009 On frame complete with the reader in R_IDLE:
- next cycle wsel SHALL toggle
- reader SHALL start on the just-filled bank with Nr = Nw
- wr_addr SHALL reset to 0
- writer SHALL stay in W_RUN
REQ-010 On frame complete with the reader busy, the writer SHALL enter W_HOLD.
REQ-011 In W_HOLD:
- every smp_valid SHALL be dropped
- overrun_cnt SHALL increment, saturating at 0xFFFF
- when the reader returns to R_IDLE, the swap per REQ-009 SHALL occur in the next cycle and the writer SHALL return to W_RUN
REQ-012 If the reader finishes in the same cycle the frame completes, the reader SHALL count as idle and the swap SHALL occur without W_HOLD.
REQ-013 Reader states R_IDLE, R_ADDR, R_WAIT, R_DATA.
- R_ADDR: drive rd_addr, oe_n=0, drv=0.
- R_WAIT: hold address and oe_n.
- R_DATA: register ram_di into rd_data, assert rd_valid, release oe_n; rd_data, rd_sop and rd_eop SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-014 In R_DATA, on rd_valid&rd_ready:
- if rd_addr = Nr-1: go to R_IDLE
- otherwise: rd_addr+1 and go to R_ADDR
REQ-015 Read latency SHALL be 3 cycles from entering R_ADDR to rd_valid.
REQ-016 rd_sop SHALL be 1 when rd_addr = 0; rd_eop SHALL be 1 when rd_addr = Nr-1.
REQ-017 The idle bank SHALL have we_n=1, oe_n=1 and drv=0; its address SHALL hold its last value.
REQ-018 All RAM control outputs SHALL be registered.

Reset
REQ-019 Reset SHALL take effect at the next clk edge, including mid-frame or mid-handshake; no partial state SHALL survive. After reset:
- rd_valid/rd_sop/rd_eop=0
- rd_data=0
- all we_n/oe_n=1
- drv=0
- addresses=0
- wsel=0
- writer in W_RUN with wr_addr=0
- reader in R_IDLE
- overrun_cnt=0, frame_cnt=0
REQ-020 The first frame after reset SHALL find the reader idle and swap immediately.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- V1: reset, len_sel=0, 256 contiguous smp_valid with ramp 0..255 -> 256 single-cycle ram_we0_n pulses at addresses 0..255; frame_cnt=1; wsel=1; reader outputs 0..255 from bank 0 with rd_sop on word 0 and rd_eop on word 255.
- V2: smp_data=0x800 -> written data 0xF800.
- V3: rd_ready held 0 while a second 256-sample frame completes -> writer in W_HOLD; next 10 smp_valid give overrun_cnt=10; after the reader drains, the swap occurs one cycle after R_IDLE and capture resumes at wr_addr 0 of bank 0.
- V4: len_sel=15 -> frame length 262144; len_sel changed mid-frame -> current frame length unchanged.
- V5: reset asserted while rd_valid=1 at word 100 -> next cycle all outputs at reset values; the next frame is written to bank 0.
- V6: rd_ready toggled randomly -> no word lost or duplicated; ram_oe and ram_we never both active on the same bank; the reader and writer banks never coincide.
